// File: rtl/pkt_bram_pkg.sv
// rtl/pkt_bram_pkg.sv - shared types and constants for the packet-buffer BRAM arbiter
package pkt_bram_pkg;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    typedef logic req_id_t;

    // Word index to byte address: 32-bit words.
    localparam int BYTE_SHIFT = 2;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/pkt_bram_rr_arb.sv
// rtl/pkt_bram_rr_arb.sv - 2-way round-robin arbiter, pointer moves past the winner on grant
module pkt_bram_rr_arb (
    input  logic       clka,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // 0 favours requester 0, 1 favours requester 1
    logic ptr;

    // Pick the favoured requester only when both ask; a lone request always wins.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

    // After a grant, favour the requester that did not win.
    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            ptr <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/pkt_bram_arb.sv
// rtl/pkt_bram_arb.sv - two-requester arbiter/controller for a dual-port packet BRAM; optional PKT_BRAM_ARB_BOUNDS_EN
module pkt_bram_arb
    import pkt_bram_pkg::*;
#(
    parameter int DW             = 32,
    parameter int AW             = 10,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1,
    parameter int MAX_WORDS      = 1024
) (
    input  logic              clka,
    input  logic              resetn,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [AW-1:0]     req0_addr,
    input  logic [DW-1:0]     req0_wdata,
    input  logic [DW/8-1:0]   req0_be,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [AW-1:0]     req1_addr,
    input  logic [DW-1:0]     req1_wdata,
    input  logic [DW/8-1:0]   req1_be,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic [DW-1:0]     rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DW-1:0]     rsp1_rdata,
    output logic [31:0]       bram_addra,
    output logic [DW-1:0]     bram_dina,
    output logic [DW/8-1:0]   bram_wea,
    output logic              bram_ena,
    output logic [31:0]       bram_addrb,
    output logic              bram_enb,
    output logic              bram_rstb,
    input  logic [DW-1:0]     bram_doutb,
    output logic              init_done,
    output logic              err_oob
);

    localparam int            DEPTH     = 1 << AW;
    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] cnt;
    logic          run;
    logic          clearing;

    logic [1:0]    wr_req;
    logic [1:0]    rd_raw;
    logic [1:0]    rd_block;
    logic [1:0]    rd_req;
    logic [1:0]    gnt_a;
    logic [1:0]    gnt_b;

    logic            wr_id;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [DW/8-1:0] wr_be;
    logic            rd_id;
    logic [AW-1:0]   rd_addr;
    logic            wr_oob;
    logic            rd_oob;
    logic            rsp_oob;

    tag_t            tag_pipe [RD_LAT+1];
    tag_t            tag_out;
    logic [DW-1:0]   rsp_data;
    logic [DW-1:0]   hold0;
    logic [DW-1:0]   hold1;

    // State register; reset picks clear or run directly.
    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Leave the clear sweep after the last word; run is terminal until reset.
    always_comb begin
        state_nxt = state;
        if ((state == S_CLEAR) && (cnt == LAST_WORD)) begin
            state_nxt = S_RUN;
        end
    end

    // State-decoded outputs.
    always_comb begin
        run       = (state == S_RUN);
        clearing  = (state == S_CLEAR);
        init_done = run;
        bram_rstb = ~run;
    end

    // Clear sweep counter; saturates at the last word.
    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clearing && (cnt != LAST_WORD)) begin
            cnt <= cnt + AW'(1);
        end
    end

    // Split requests by direction; stall a read that hits the address being written this cycle.
    always_comb begin
        wr_req      = {req1_valid & req1_we, req0_valid & req0_we} & {2{run}};
        rd_raw      = {req1_valid & ~req1_we, req0_valid & ~req0_we} & {2{run}};
        rd_block[0] = rd_raw[0] & wr_req[1] & (req0_addr == req1_addr);
        rd_block[1] = rd_raw[1] & wr_req[0] & (req0_addr == req1_addr);
        rd_req      = rd_raw & ~rd_block;
    end

    pkt_bram_rr_arb u_arb_a (
        .clka    (clka),
        .resetn  (resetn),
        .req     (wr_req),
        .advance (|gnt_a),
        .grant   (gnt_a)
    );

    pkt_bram_rr_arb u_arb_b (
        .clka    (clka),
        .resetn  (resetn),
        .req     (rd_req),
        .advance (|gnt_b),
        .grant   (gnt_b)
    );

    assign req0_ready = gnt_a[0] | gnt_b[0];
    assign req1_ready = gnt_a[1] | gnt_b[1];

    // Steer the winning requester's fields to each port.
    always_comb begin
        wr_id   = gnt_a[1];
        wr_addr = wr_id ? req1_addr  : req0_addr;
        wr_data = wr_id ? req1_wdata : req0_wdata;
        wr_be   = wr_id ? req1_be    : req0_be;
        rd_id   = gnt_b[1];
        rd_addr = rd_id ? req1_addr  : req0_addr;
    end

`ifdef PKT_BRAM_ARB_BOUNDS_EN
    localparam logic [AW:0] MAX_W = (AW+1)'(MAX_WORDS);

    logic [RD_LAT:0] oob_pipe;

    assign wr_oob  = ({1'b0, wr_addr} >= MAX_W);
    assign rd_oob  = ({1'b0, rd_addr} >= MAX_W);
    assign rsp_oob = oob_pipe[RD_LAT];

    // Out-of-range reads travel alongside their tag so the response can be forced to zero.
    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            oob_pipe <= '0;
        end else begin
            oob_pipe <= {oob_pipe[RD_LAT-1:0], (|gnt_b) & rd_oob};
        end
    end

    // One-cycle error pulse for any accepted out-of-range access.
    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            err_oob <= 1'b0;
        end else begin
            err_oob <= ((|gnt_a) & wr_oob) | ((|gnt_b) & rd_oob);
        end
    end
`else
    assign wr_oob  = 1'b0;
    assign rd_oob  = 1'b0;
    assign rsp_oob = 1'b0;
    assign err_oob = 1'b0;
`endif

    // Port A: zero-fill during clear, otherwise issue the granted write.
    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            bram_addra <= '0;
            bram_dina  <= '0;
            bram_wea   <= '0;
            bram_ena   <= 1'b0;
        end else if (clearing) begin
            bram_addra <= 32'(cnt) << BYTE_SHIFT;
            bram_dina  <= '0;
            bram_wea   <= '1;
            bram_ena   <= 1'b1;
        end else if ((|gnt_a) && !wr_oob) begin
            bram_addra <= 32'(wr_addr) << BYTE_SHIFT;
            bram_dina  <= wr_data;
            bram_wea   <= wr_be;
            bram_ena   <= 1'b1;
        end else begin
            bram_wea   <= '0;
            bram_ena   <= 1'b0;
        end
    end

    // Port B: issue the granted read.
    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            bram_addrb <= '0;
            bram_enb   <= 1'b0;
        end else if ((|gnt_b) && !rd_oob) begin
            bram_addrb <= 32'(rd_addr) << BYTE_SHIFT;
            bram_enb   <= 1'b1;
        end else begin
            bram_enb   <= 1'b0;
        end
    end

    // Tag pipeline lines the requester id up with the BRAM output; reset drops in-flight reads.
    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= {|gnt_b, gnt_b[1]};
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign tag_out    = tag_pipe[RD_LAT];
    assign rsp_data   = rsp_oob ? '0 : bram_doutb;
    assign rsp0_valid = tag_out.valid & (tag_out.id == 1'b0);
    assign rsp1_valid = tag_out.valid & (tag_out.id == 1'b1);
    assign rsp0_rdata = rsp0_valid ? rsp_data : hold0;
    assign rsp1_rdata = rsp1_valid ? rsp_data : hold1;

    // Keep the last returned word visible between response strobes.
    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            hold0 <= '0;
            hold1 <= '0;
        end else begin
            hold0 <= rsp0_rdata;
            hold1 <= rsp1_rdata;
        end
    end

endmodule

// File: tb/tb_pkt_bram_arb.sv
// tb/tb_pkt_bram_arb.sv - randomized and directed bench for pkt_bram_arb with a word-level reference model
module tb_pkt_bram_arb;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;
    localparam int MAXW  = 512;

    logic          clka   = 1'b0;
    logic          resetn = 1'b1;
    logic          req0_valid, req0_we, req1_valid, req1_we;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [31:0]   req0_wdata, req1_wdata;
    logic [3:0]    req0_be, req1_be;
    logic          req0_ready, req1_ready;
    logic          rsp0_valid, rsp1_valid;
    logic [31:0]   rsp0_rdata, rsp1_rdata;
    logic [31:0]   bram_addra, bram_dina, bram_addrb;
    logic [3:0]    bram_wea;
    logic          bram_ena, bram_enb, bram_rstb;
    logic [31:0]   bram_doutb = '0;
    logic          init_done, err_oob;

    always #5 clka = ~clka;

    pkt_bram_arb #(
        .DW(DW), .AW(AW), .RD_LAT(1), .CLEAR_ON_RESET(1), .MAX_WORDS(MAXW)
    ) dut (
        .clka(clka), .resetn(resetn),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_be(req0_be), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_be(req1_be), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .bram_addra(bram_addra), .bram_dina(bram_dina), .bram_wea(bram_wea),
        .bram_ena(bram_ena), .bram_addrb(bram_addrb), .bram_enb(bram_enb),
        .bram_rstb(bram_rstb), .bram_doutb(bram_doutb),
        .init_done(init_done), .err_oob(err_oob)
    );

    // BRAM: starts full of garbage so the clear sweep is observable
    logic [31:0] bmem [0:DEPTH-1];
    bit          filled = 1'b0;
    always @(posedge clka) begin
        if (!filled) begin
            for (int i = 0; i < DEPTH; i++) bmem[i] <= $urandom;
            filled <= 1'b1;
        end else if (bram_ena) begin
            for (int b = 0; b < 4; b++)
                if (bram_wea[b]) bmem[bram_addra[11:2]][8*b +: 8] <= bram_dina[8*b +: 8];
        end
        if (bram_rstb) bram_doutb <= '0;
        else if (bram_enb) bram_doutb <= bmem[bram_addrb[11:2]];
    end

    // Reference model state
    typedef struct { int cyc; logic [31:0] data; } rsp_t;
    int          tests = 0;
    int          fails = 0;
    int          k = 0;
    logic [31:0] ref_mem [0:DEPTH-1];
    rsp_t        rq0[$];
    rsp_t        rq1[$];
    logic [31:0] last0, last1;
    bit          lw_last, lr_last;
    bit          p_wr, p_rd, p_oob;
    logic [31:0] p_wa, p_wd, p_ra;
    logic [3:0]  p_wbe;
    bit          s_r0, s_r1, s_v0, s_v1, s_enb, s_oob, s_ena;
    logic [31:0] s_d0, s_d1, s_addra;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, k);
        end
    endtask

    function automatic bit is_oob(input logic [AW-1:0] a);
`ifdef PKT_BRAM_ARB_BOUNDS_EN
        return int'(a) >= MAXW;
`else
        return (a != a);
`endif
    endfunction

    task automatic do_reset(input int hold);
        resetn = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clka);
            chk("rst_ready0", req0_ready, 0);
            chk("rst_init_done", init_done, 0);
            chk("rst_bram_rstb", bram_rstb, 1);
            chk("rst_ena", bram_ena, 0);
            chk("rst_enb", bram_enb, 0);
            chk("rst_addra", bram_addra, 0);
            chk("rst_rsp0_valid", rsp0_valid, 0);
            chk("rst_rsp1_valid", rsp1_valid, 0);
            chk("rst_rsp0_rdata", rsp0_rdata, 0);
            chk("rst_err_oob", err_oob, 0);
        end
        @(posedge clka); #1;
        resetn = 1'b1;
        k = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        rq0.delete(); rq1.delete();
        last0 = '0; last1 = '0;
        lw_last = 1'b1; lr_last = 1'b1;
        p_wr = 0; p_rd = 0; p_oob = 0;
    endtask

    // One clock: compare every observable output against the model at the negedge, then advance the model.
    task automatic cycle();
        bit run, wv0, wv1, rv0, rv1, gw0, gw1, gr0, gr1, ob;
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [3:0]    be;
        rsp_t          r;
        @(negedge clka);
        run = (k >= DEPTH);
        chk("init_done", init_done, run);
        chk("bram_rstb", bram_rstb, !run);
        wv0 = run && req0_valid && req0_we;
        wv1 = run && req1_valid && req1_we;
        rv0 = run && req0_valid && !req0_we;
        rv1 = run && req1_valid && !req1_we;
        gw0 = wv0 && (!wv1 || lw_last);
        gw1 = wv1 && (!wv0 || !lw_last);
        if (gw0 && rv1 && req1_addr == req0_addr) rv1 = 0;
        if (gw1 && rv0 && req0_addr == req1_addr) rv0 = 0;
        gr0 = rv0 && (!rv1 || lr_last);
        gr1 = rv1 && (!rv0 || !lr_last);
        s_r0 = req0_ready; s_r1 = req1_ready;
        chk("req0_ready", req0_ready, gw0 || gr0);
        chk("req1_ready", req1_ready, gw1 || gr1);

        s_ena = bram_ena; s_addra = bram_addra; s_enb = bram_enb; s_oob = err_oob;
        if (k >= 1 && k <= DEPTH) begin
            chk("clr_ena", bram_ena, 1);
            chk("clr_addra", bram_addra, 32'(k - 1) << 2);
            chk("clr_dina", bram_dina, 0);
            chk("clr_wea", bram_wea, 4'hf);
        end else if (p_wr) begin
            chk("wr_ena", bram_ena, 1);
            chk("wr_addra", bram_addra, p_wa);
            chk("wr_dina", bram_dina, p_wd);
            chk("wr_wea", bram_wea, p_wbe);
        end else begin
            chk("idle_ena", bram_ena, 0);
        end
        chk("enb", bram_enb, p_rd);
        if (p_rd) chk("addrb", bram_addrb, p_ra);
        chk("err_oob", err_oob, p_oob);

        s_v0 = rsp0_valid; s_d0 = rsp0_rdata; s_v1 = rsp1_valid; s_d1 = rsp1_rdata;
        if (rq0.size() > 0 && rq0[0].cyc == k) begin
            r = rq0.pop_front();
            chk("rsp0_valid", rsp0_valid, 1);
            chk("rsp0_rdata", rsp0_rdata, r.data);
            last0 = r.data;
        end else begin
            chk("rsp0_valid", rsp0_valid, 0);
            chk("rsp0_hold", rsp0_rdata, last0);
        end
        if (rq1.size() > 0 && rq1[0].cyc == k) begin
            r = rq1.pop_front();
            chk("rsp1_valid", rsp1_valid, 1);
            chk("rsp1_rdata", rsp1_rdata, r.data);
            last1 = r.data;
        end else begin
            chk("rsp1_valid", rsp1_valid, 0);
            chk("rsp1_hold", rsp1_rdata, last1);
        end

        p_oob = 0;
        p_wr  = 0;
        if (gw0 || gw1) begin
            lw_last = gw1;
            a  = gw1 ? req1_addr  : req0_addr;
            d  = gw1 ? req1_wdata : req0_wdata;
            be = gw1 ? req1_be    : req0_be;
            ob = is_oob(a);
            p_oob = ob;
            if (!ob) begin
                for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
                p_wr = 1; p_wa = 32'(a) << 2; p_wd = d; p_wbe = be;
            end
        end
        p_rd = 0;
        if (gr0 || gr1) begin
            lr_last = gr1;
            a  = gr1 ? req1_addr : req0_addr;
            ob = is_oob(a);
            p_oob = p_oob || ob;
            r.cyc  = k + 2;
            r.data = ob ? 32'h0 : ref_mem[a];
            if (gr1) rq1.push_back(r); else rq0.push_back(r);
            if (!ob) begin p_rd = 1; p_ra = 32'(a) << 2; end
        end
        @(posedge clka);
        k++;
        #1;
    endtask

    task automatic rand_req(output logic v, output logic we, output logic [AW-1:0] a,
                            output logic [31:0] d, output logic [3:0] be);
        v  = ($urandom % 4) != 0;
        we = $urandom % 2;
        a  = AW'($urandom % 8);
        d  = $urandom;
        be = 4'($urandom % 16);
    endtask

    initial begin
        int n;
        req0_valid = 1; req0_we = 0; req0_addr = 10'd8; req0_wdata = '0; req0_be = '0;
        req1_valid = 0; req1_we = 0; req1_addr = '0;    req1_wdata = '0; req1_be = '0;
        #2;
        do_reset(3);

        // clear sweep length; req0 read of word 8 held throughout
        for (n = 0; n < 2000 && !init_done; n++) cycle();
        chk("clear_len", n, 1024);
        cycle();
        req0_valid = 0;
        cycle(); cycle();
        chk("post_clear_rd_valid", s_v0, 1);
        chk("post_clear_rd_data", s_d0, 32'h0);

        // both writing every cycle: alternation starting with req0
        req0_valid = 1; req0_we = 1; req0_addr = 10'd1; req0_wdata = 32'ha0; req0_be = 4'hf;
        req1_valid = 1; req1_we = 1; req1_addr = 10'd2; req1_wdata = 32'hb0; req1_be = 4'hf;
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk("rr_grant0", s_r0, (c % 2) == 0);
            chk("rr_grant1", s_r1, (c % 2) == 1);
            if (s_r0) req0_wdata = req0_wdata + 1;
            if (s_r1) req1_wdata = req1_wdata + 1;
        end
        req0_valid = 0; req1_valid = 0;
        cycle();
        req0_valid = 1; req1_valid = 1;
        cycle();
        chk("rr_after_idle0", s_r0, 1);
        chk("rr_after_idle1", s_r1, 0);
        req0_valid = 0; req1_valid = 0;
        cycle();

        // write/read collision on word 5
        req0_valid = 1; req0_we = 1; req0_addr = 10'd5; req0_wdata = 32'h12345678; req0_be = 4'hf;
        req1_valid = 1; req1_we = 0; req1_addr = 10'd5;
        cycle();
        chk("coll_wr_ready", s_r0, 1);
        chk("coll_rd_stall", s_r1, 0);
        req0_valid = 0;
        cycle();
        chk("coll_rd_grant", s_r1, 1);
        req1_valid = 0;
        cycle(); cycle();
        chk("coll_rsp_valid", s_v1, 1);
        chk("coll_rsp_data", s_d1, 32'h12345678);

        // write word 8 by req0, read back by req1
        req0_valid = 1; req0_we = 1; req0_addr = 10'd8; req0_wdata = 32'hdeadface; req0_be = 4'hf;
        cycle();
        req0_valid = 0;
        req1_valid = 1; req1_we = 0; req1_addr = 10'd8;
        cycle();
        chk("w8_addra", s_addra, 32'h20);
        req1_valid = 0;
        cycle(); cycle();
        chk("w8_rsp1_valid", s_v1, 1);
        chk("w8_rsp1_data", s_d1, 32'hdeadface);
        chk("w8_rsp0_quiet", s_v0, 0);

`ifdef PKT_BRAM_ARB_BOUNDS_EN
        req0_valid = 1; req0_we = 0; req0_addr = 10'd600;
        cycle();
        chk("oob_ready", s_r0, 1);
        req0_valid = 0;
        cycle();
        chk("oob_enb", s_enb, 0);
        chk("oob_err", s_oob, 1);
        cycle();
        chk("oob_rsp_valid", s_v0, 1);
        chk("oob_rsp_data", s_d0, 32'h0);
        chk("oob_err_once", s_oob, 0);
`endif

        // randomized traffic on a small address window to provoke contention and collisions
        for (int i = 0; i < 3000; i++) begin
            if (!(req0_valid && !s_r0)) rand_req(req0_valid, req0_we, req0_addr, req0_wdata, req0_be);
            if (!(req1_valid && !s_r1)) rand_req(req1_valid, req1_we, req1_addr, req1_wdata, req1_be);
            cycle();
        end
        req0_valid = 0; req1_valid = 0;
        for (int i = 0; i < 4; i++) cycle();

        // reset with a read in flight: no response, clear restarts at word 0
        req1_valid = 1; req1_we = 0; req1_addr = 10'd3;
        cycle();
        chk("mid_rd_grant", s_r1, 1);
        req1_valid = 0;
        cycle();
        do_reset(3);
        cycle(); cycle();
        chk("restart_ena", s_ena, 1);
        chk("restart_addra", s_addra, 32'h0);
        for (int i = 0; i < 4; i++) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pkt_bram_arb.md
Name: pkt_bram_arb

Overview:
Controller and arbiter that shares one dual-port packet-buffer BRAM (byte-addressed 32-bit, byte write enables) between two requesters: req0 is the parser packet writer/reader and req1 is the config/debug port. All writes go to BRAM port A and all reads go to port B. The block round-robins each port independently, returns read data tagged to the issuing requester, and zero-fills the memory after reset.

Parameters:
DW, 32, data width; must be a multiple of 8.
AW, 10, word-address width; DEPTH = 2**AW words.
RD_LAT, 1, BRAM read latency in cycles (1 or 2).
CLEAR_ON_RESET, 1, 1 = zero-fill all words after reset; 0 = go straight to run.
MAX_WORDS, 1024, highest legal word index + 1 (used only with the optional feature).

Ports:
clka  in  1  single clock for the block and both BRAM ports
resetn  in  1  asynchronous active-low reset
reqN_valid  in  1  request valid; N = 0, 1
reqN_we  in  1  1 = write, 0 = read
reqN_addr  in  AW  word address
reqN_wdata  in  DW  write data
reqN_be  in  DW/8  byte enables
reqN_ready  out  1  grant; combinational, valid-dependent
rspN_valid  out  1  one-cycle read-data strobe
rspN_rdata  out  DW  read data
bram_addra  out  32  byte address = word << 2
bram_dina  out  DW  write data
bram_wea  out  DW/8  byte write enables
bram_ena  out  1  port A enable
bram_addrb  out  32  byte address = word << 2
bram_enb  out  1  port B enable
bram_rstb  out  1  port B output-register reset, active-high
bram_doutb  in  DW  port B read data
init_done  out  1  high once the RUN state is reached
err_oob  out  1  out-of-bounds pulse

Behaviour:
- Reset values: all outputs 0; bram_rstb = 1; FSM = S_CLEAR if CLEAR_ON_RESET else S_RUN; clear counter = 0; both round-robin pointers favour req0.
- FSM S_CLEAR:
  - Each cycle write 0 to word cnt, with bram_ena = 1 and bram_wea all-ones.
  - cnt increments; when cnt == DEPTH-1, go to S_RUN on the next edge. No wrap-around.
  - reqN_ready = 0 and bram_rstb = 1 throughout.
- FSM S_RUN: bram_rstb = 0; init_done = 1. The FSM stays in S_RUN until reset.
- Reset asserted mid-clear or mid-run: FSM restarts immediately per reset values. In-flight read responses are discarded; no rsp_valid follows reset.
- Arbitration (S_RUN only), evaluated in cycle t:
  - Write and read candidates are separated by reqN_we.
  - If one requester writes and the other reads, both are granted in the same cycle.
  - If both request the same port, the round-robin pointer picks; the pointer moves past the winner only on a grant.
  - A requester holding reqN_valid without ready must keep its request stable.
- Collision: if a write and a read are granted-eligible in the same cycle with the same reqN_addr, the read is stalled for that cycle (ready = 0, read pointer unchanged). The write proceeds.
- Issue timing:
  - bram_* are registered on the edge ending cycle t.
  - bram_ena/enb are high only in cycles that carry a granted access.
  - Unused data/address outputs hold their previous value.
- Read return:
  - A tag shift pipeline of depth 1+RD_LAT carries the requester id.
  - rspN_valid is asserted in cycle t+1+RD_LAT with rspN_rdata = bram_doutb.
  - rspN_rdata holds its value when rspN_valid is low.
  - Back-to-back reads are fully pipelined, one per cycle per port.
- Addresses are AW bits; the byte address is zero-extended to 32 bits.

Optional Feature:
PKT_BRAM_ARB_BOUNDS_EN
- Defined:
  - A request with addr >= MAX_WORDS is accepted (ready per normal arbitration) but never reaches the BRAM.
  - A write is dropped.
  - A read returns rspN_valid at the normal latency with rdata = 0.
  - err_oob pulses for 1 cycle, registered, at t+1.
- Undefined: no check is made; err_oob is tied to 0.

Decomposition:
- Package pkt_bram_pkg:
  - state enum (S_CLEAR, S_RUN)
  - req_id_t (1-bit requester tag)
  - byte-shift constant BYTE_SHIFT = 2
  - read-tag pipeline entry struct {valid, id}
- Sub-module pkt_bram_rr_arb: 2-way round-robin, with inputs req[1:0] and advance, output grant[1:0]. It is instantiated twice, once for port A and once for port B.

Test Plan:
- Reset with CLEAR_ON_RESET=1, AW=10 -> init_done rises exactly 1024 cycles after resetn deasserts; bram_wea = 4'hf and bram_dina = 0 on every clear cycle; a read of word 8 afterwards returns 0.
- req0 write word 8, data 32'hdeadface, be 4'hf; then req1 read word 8 -> bram_addra = 32'h20; rsp1_valid at t+2 (RD_LAT=1) with 32'hdeadface; rsp0_valid stays 0.
- req0 and req1 both write every cycle for 4 cycles -> grants alternate 0,1,0,1; no requester starves; the pointer is unchanged on idle cycles.
- Same cycle: req0 write word 5 = 32'h12345678 and req1 read word 5 -> req1 ready = 0 for 1 cycle, then granted; rsp1_rdata = 32'h12345678.
- Reset asserted 2 cycles after a read grant -> no rsp valid ever appears; FSM re-enters S_CLEAR at cnt 0.
- With PKT_BRAM_ARB_BOUNDS_EN and MAX_WORDS=512: req0 read word 600 -> bram_enb stays 0; rsp0_valid with rdata 0; err_oob pulses once.
